regfile_mp_dump: RTL and testbench

//  Parametrised successor to the core register file: NRD synchronous read ports, one write port,

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/dump_byte_serializer.sv | 71 +++++++
 rtl/regfile_mp_dump.sv | 153 +++++++++++++++
 tb/tb_regfile_mp_dump.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its dump engine.
// No logic; latency and backpressure are defined by the modules that import it.
package regfile_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        IDX  = 3'd2,
        DATA = 3'd3,
        END  = 3'd4
    } dump_state_t;

    localparam logic [7:0] DUMP_END_BYTE = 8'hFF;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/dump_byte_serializer.sv
// Presents an index byte, then a word LSB-first, or a lone END byte, as a valid/ready byte stream.
// Load-to-valid latency 1 cycle; holds data and last stable while valid && !ready.
module dump_byte_serializer
    import regfile_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            loadEnd,
    input  logic [7:0]      loadIdx,
    input  logic [XLEN-1:0] loadWord,
    output logic            outValid,
    input  logic            outReady,
    output logic [7:0]      outData,
    output logic            outLast,
    output logic            done
);

    localparam int NB = XLEN / 8;
    localparam int CW = (clog2(NB) < 1) ? 1 : clog2(NB);
    localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);

    logic            isEnd;
    logic            isIdx;
    logic [CW-1:0]   cnt;
    logic [7:0]      idxByte;
    logic [XLEN-1:0] word;
    logic            xfer;

    assign xfer     = outValid && outReady;
    assign outData  = isEnd ? DUMP_END_BYTE : (isIdx ? idxByte : word[7:0]);
    assign outLast  = isEnd;
    assign done     = xfer && !isIdx && (isEnd || cnt == LAST_CNT);

    // loadEnd may coincide with the final data transfer and must win over it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid <= 1'b0;
            isEnd    <= 1'b0;
            isIdx    <= 1'b0;
            cnt      <= '0;
            idxByte  <= '0;
            word     <= '0;
        end else if (load) begin
            outValid <= 1'b1;
            isEnd    <= 1'b0;
            isIdx    <= 1'b1;
            cnt      <= '0;
            idxByte  <= loadIdx;
            word     <= loadWord;
        end else if (loadEnd) begin
            outValid <= 1'b1;
            isEnd    <= 1'b1;
            isIdx    <= 1'b0;
        end else if (xfer) begin
            if (isEnd) begin
                outValid <= 1'b0;
                isEnd    <= 1'b0;
            end else if (isIdx) begin
                isIdx <= 1'b0;
            end else begin
                word <= word >> 8;
                cnt  <= cnt + CW'(1);
                if (cnt == LAST_CNT) outValid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp_dump.sv
// NRD-read/1-write flop register file (x0 hardwired) with dirty tracking and a byte-stream dump engine.
// Reads: 1 cycle, optional write-first bypass; dump: stalls on dump_ready, never stalls reads/writes.
module regfile_mp_dump
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [AW-1:0]         wrAddr,
    input  logic [XLEN-1:0]       wrData,
    input  logic [NRD*AW-1:0]     rdAddr,
    output logic [NRD*XLEN-1:0]   rdData,
    output logic [NREGS*XLEN-1:0] regfilePort,
    input  logic                  dump_start,
    input  logic                  dump_dirty_only,
    output logic                  dump_busy,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [7:0]            dump_data,
    output logic                  dump_last
);

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           dirty;
    logic                       wrEn;

    dump_state_t                state;
    logic [AW-1:0]              ptr;
    logic                       modeAll;
    logic                       ptrLast;
    logic                       selected;
    logic                       capture;
    logic                       loadEnd;
    logic                       serDone;
    logic                       xfer;

    assign wrEn        = write && (wrAddr != '0);
    assign regfilePort = regs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else if (wrEn) begin
            regs[wrAddr] <= wrData;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] rdNext;
        logic [XLEN-1:0] rdQ;

        assign addr = rdAddr[p*AW +: AW];

        always_comb begin
            rdNext = regs[addr];
            if (addr == '0) begin
                rdNext = '0;
            end else if (BYPASS != 0 && wrEn && wrAddr == addr) begin
                rdNext = wrData;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) rdQ <= '0;
            else       rdQ <= rdNext;
        end

        assign rdData[p*XLEN +: XLEN] = rdQ;
    end

    assign ptrLast  = (ptr == AW'(NREGS - 1));
    assign selected = modeAll || (dirty[ptr] && ptr != '0);
    assign capture  = (state == SCAN) && selected;
    assign xfer     = dump_valid && dump_ready;
    assign loadEnd  = ((state == SCAN) && !selected && ptrLast) ||
                      ((state == DATA) && serDone && ptrLast);
    assign dump_busy = (state != IDLE);

    // A write landing on the register being captured keeps it dirty: the write is assigned last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dirty <= '0;
        end else begin
            if (capture) dirty[ptr]    <= 1'b0;
            if (wrEn)    dirty[wrAddr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            modeAll <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dump_start) begin
                        state   <= SCAN;
                        ptr     <= '0;
                        modeAll <= !dump_dirty_only;
                    end
                end
                SCAN: begin
                    if (selected)     state <= IDX;
                    else if (ptrLast) state <= END;
                    else              ptr   <= ptr + AW'(1);
                end
                IDX: begin
                    if (xfer) state <= DATA;
                end
                DATA: begin
                    if (serDone) begin
                        if (ptrLast) begin
                            state <= END;
                        end else begin
                            state <= SCAN;
                            ptr   <= ptr + AW'(1);
                        end
                    end
                end
                END: begin
                    if (xfer) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The captured word is the pre-write storage value, so writes never alter bytes in flight.
    dump_byte_serializer #(
        .XLEN(XLEN)
    ) u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (capture),
        .loadEnd  (loadEnd),
        .loadIdx  (8'(ptr)),
        .loadWord (regs[ptr]),
        .outValid (dump_valid),
        .outReady (dump_ready),
        .outData  (dump_data),
        .outLast  (dump_last),
        .done     (serDone)
    );

endmodule

// File: tb/tb_regfile_mp_dump.sv
// Directed + randomized bench for regfile_mp_dump against an array/queue reference model.
module tb_regfile_mp_dump;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          write = 1'b0;
    logic [4:0]    wrAddr = '0;
    logic [31:0]   wrData = '0;
    logic [9:0]    rdAddr = '0;
    logic [63:0]   rdData, rdDataNb;
    logic [1023:0] regfilePort, regfilePortNb;
    logic          dump_start = 1'b0;
    logic          dump_dirty_only = 1'b0;
    logic          dump_ready = 1'b1;
    logic          dump_busy, dump_valid, dump_last;
    logic [7:0]    dump_data;
    logic          busyNb, validNb, lastNb;
    logic [7:0]    dataNb;

    int            nChecks = 0;
    int            nErrors = 0;
    logic [31:0]   model [32];
    bit            mdirty [32];
    logic [7:0]    expQ [$];

    regfile_mp_dump #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddr(rdAddr), .rdData(rdData), .regfilePort(regfilePort),
        .dump_start(dump_start), .dump_dirty_only(dump_dirty_only), .dump_busy(dump_busy),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data), .dump_last(dump_last)
    );

    regfile_mp_dump #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dutNb (
        .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddr(rdAddr), .rdData(rdDataNb), .regfilePort(regfilePortNb),
        .dump_start(dump_start), .dump_dirty_only(dump_dirty_only), .dump_busy(busyNb),
        .dump_valid(validNb), .dump_ready(dump_ready), .dump_data(dataNb), .dump_last(lastNb)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic writeReg(input int a, input logic [31:0] d);
        write  = 1'b1;
        wrAddr = 5'(a);
        wrData = d;
        step();
        write  = 1'b0;
        if (a != 0) begin
            model[a]  = d;
            mdirty[a] = 1'b1;
        end
    endtask

    function automatic logic [31:0] refRead(input int a, input bit byp, input bit we,
                                            input int wa, input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (byp && we && wa == a) return wd;
        return model[a];
    endfunction

    task automatic expReg(input int idx, input logic [31:0] val);
        expQ.push_back(8'(idx));
        for (int b = 0; b < 4; b++) expQ.push_back(val[b*8 +: 8]);
    endtask

    // Expected stream from the model when no writes overlap the dump; selected regs become clean.
    task automatic buildExp(input bit all);
        expQ.delete();
        for (int i = 0; i < 32; i++) begin
            if (all || (mdirty[i] && i != 0)) begin
                expReg(i, model[i]);
                mdirty[i] = 1'b0;
            end
        end
        expQ.push_back(8'hFF);
    endtask

    task automatic startDump(input bit dirtyOnly, input string tag);
        dump_start      = 1'b1;
        dump_dirty_only = dirtyOnly;
        step();
        dump_start = 1'b0;
        check({tag, "_busy_start"}, dump_busy, 1);
    endtask

    task automatic collect(input string tag, input bit randReady);
        int         k;
        int         n;
        int         cyc;
        bit         done;
        bit         prevStall;
        bit         rdy;
        logic       v, l, prevLast;
        logic [7:0] d, prevData;
        k = 0; cyc = 0; done = 0; prevStall = 0; prevData = '0; prevLast = 1'b0;
        n = expQ.size();
        while (!done && cyc < 4000) begin
            v = dump_valid; d = dump_data; l = dump_last;
            if (prevStall) begin
                check({tag, "_hold_vld"}, v, 1);
                check({tag, "_hold_dat"}, d, prevData);
                check({tag, "_hold_last"}, l, prevLast);
            end
            rdy = randReady ? ($urandom_range(0, 1) == 1) : 1'b1;
            dump_ready = rdy;
            if (v && rdy) begin
                if (k < n) begin
                    check({tag, "_byte"}, d, expQ[k]);
                    check({tag, "_last"}, l, (k == n - 1));
                end else begin
                    check({tag, "_overrun"}, k, n - 1);
                end
                k++;
                if (l) done = 1;
            end
            prevStall = v && !rdy;
            prevData  = d;
            prevLast  = l;
            step();
            cyc++;
        end
        dump_ready = 1'b1;
        check({tag, "_nbytes"}, k, n);
        check({tag, "_busy_end"}, dump_busy, 0);
        check({tag, "_vld_end"}, dump_valid, 0);
    endtask

    initial begin
        bit          we;
        int          wa, ra0, ra1;
        logic [31:0] wd;

        for (int i = 0; i < 32; i++) begin
            model[i] = '0;
            mdirty[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd", rdData, 0);
        check("rst_vld", dump_valid, 0);
        check("rst_busy", dump_busy, 0);
        check("rst_last", dump_last, 0);
        check("rst_port", 64'(|regfilePort), 0);
        reset = 1'b0;
        step();

        // Basic write then read on two ports.
        writeReg(5, 32'hDEADBEEF);
        rdAddr = {5'd0, 5'd5};
        step();
        check("t1_p0", rdData[31:0], 32'hDEADBEEF);
        check("t1_p1", rdData[63:32], 0);
        check("t1_port", regfilePort[5*32 +: 32], 32'hDEADBEEF);

        // Same-cycle write/read with and without bypass.
        writeReg(7, 32'h0BADF00D);
        write = 1'b1; wrAddr = 5'd7; wrData = 32'h12345678;
        rdAddr = {5'd0, 5'd7};
        step();
        write = 1'b0;
        model[7] = 32'h12345678; mdirty[7] = 1'b1;
        check("t2_byp", rdData[31:0], 32'h12345678);
        check("t2_nobyp", rdDataNb[31:0], 32'h0BADF00D);
        step();
        check("t2_after_nb", rdDataNb[31:0], 32'h12345678);

        // x0 writes are dropped, even with bypass.
        write = 1'b1; wrAddr = 5'd0; wrData = 32'hFFFFFFFF;
        rdAddr = {5'd0, 5'd0};
        step();
        write = 1'b0;
        check("t2_x0_byp", rdData, 0);
        step();
        check("t2_x0_rd", rdData, 0);
        check("t2_x0_port", regfilePort[31:0], 0);

        // Random concurrent reads/writes.
        for (int it = 0; it < 30; it++) begin
            we  = ($urandom_range(0, 1) == 1);
            wa  = $urandom_range(0, 31);
            wd  = $urandom;
            ra0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 31);
            ra1 = $urandom_range(0, 31);
            write = we; wrAddr = 5'(wa); wrData = wd;
            rdAddr = {5'(ra1), 5'(ra0)};
            step();
            check("rnd_p0", rdData[31:0], refRead(ra0, 1, we, wa, wd));
            check("rnd_p1", rdData[63:32], refRead(ra1, 1, we, wa, wd));
            check("rnd_nb_p0", rdDataNb[31:0], refRead(ra0, 0, we, wa, wd));
            check("rnd_nb_p1", rdDataNb[63:32], refRead(ra1, 0, we, wa, wd));
            if (we && wa != 0) begin
                model[wa]  = wd;
                mdirty[wa] = 1'b1;
            end
        end
        write = 1'b0;

        buildExp(0);
        startDump(1, "rnd_dirty");
        collect("rnd_dirty", 1);

        // Dirty-only dump of exactly x1 and x3, then a repeat with nothing dirty.
        writeReg(1, 32'h11223344);
        writeReg(3, 32'hA5A5A5A5);
        expQ.delete();
        expReg(1, 32'h11223344);
        expReg(3, 32'hA5A5A5A5);
        expQ.push_back(8'hFF);
        mdirty[1] = 1'b0; mdirty[3] = 1'b0;
        startDump(1, "t3");
        collect("t3", 0);
        expQ.delete();
        expQ.push_back(8'hFF);
        startDump(1, "t3_rep");
        collect("t3_rep", 0);

        // All-registers dump under random backpressure.
        buildExp(1);
        startDump(0, "t4");
        collect("t4", 1);

        // Write x3 in the very cycle it is captured (SCAN reaches ptr 3 three cycles after start).
        writeReg(3, 32'h5555AAAA);
        expQ.delete();
        expReg(3, 32'h5555AAAA);
        expQ.push_back(8'hFF);
        startDump(1, "t5");
        step(); step(); step();
        write = 1'b1; wrAddr = 5'd3; wrData = 32'hC0FFEE00;
        step();
        write = 1'b0;
        model[3] = 32'hC0FFEE00; mdirty[3] = 1'b1;
        collect("t5", 0);
        check("t5_port", regfilePort[3*32 +: 32], 32'hC0FFEE00);
        buildExp(0);
        startDump(1, "t5_redump");
        collect("t5_redump", 0);

        // Reset in the middle of DATA.
        writeReg(2, 32'h01020304);
        rdAddr = {5'd0, 5'd2};
        startDump(0, "t6");
        step(); step(); step();
        check("t6_pre_vld", dump_valid, 1);
        check("t6_pre_rd", rdData[31:0], 32'h01020304);
        reset = 1'b1;
        #1;
        check("t6_vld", dump_valid, 0);
        check("t6_busy", dump_busy, 0);
        check("t6_last", dump_last, 0);
        check("t6_rd", rdData, 0);
        check("t6_port", 64'(|regfilePort), 0);
        for (int i = 0; i < 32; i++) begin
            model[i] = '0;
            mdirty[i] = 1'b0;
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        expQ.delete();
        expQ.push_back(8'hFF);
        startDump(1, "t6_after");
        collect("t6_after", 0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
